// File: rtl/alu_arbiter_if.sv
// Bundle between alu_arbiter and its surroundings: two request channels,
// the shared response channel and the link to the external ALU_16.
interface alu_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int OP_W  = 3
);
   logic             req0_valid;
   logic [OP_W-1:0]  req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_ready;

   logic             req1_valid;
   logic [OP_W-1:0]  req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_ready;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_z;
   logic             rsp_v;
   logic             rsp_n;

   logic             busy;

   logic [OP_W-1:0]  alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_out;
   logic             alu_z;
   logic             alu_v;
   logic             alu_n;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      input  alu_out, alu_z, alu_v, alu_n,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_z, rsp_v, rsp_n,
      output busy,
      output alu_op, alu_a, alu_b
   );

   // Requesters, response consumer and ALU side
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      output alu_out, alu_z, alu_v, alu_n,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_z, rsp_v, rsp_n,
      input  busy,
      input  alu_op, alu_a, alu_b
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU_16 between two requesters.
// Accepted operands are registered and drive the ALU for one EXEC cycle; the
// result and flags are captured and held on the response channel until taken.
// A response handshake may coincide with the next accept (back-to-back).
module alu_arbiter #(
   parameter int WIDTH = 16,
   parameter int OP_W  = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             w_accept;
   logic             w_grant;
   logic             w_winner;
   logic [OP_W-1:0]  w_op;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;

   logic             r_last_grant;
   logic             r_id;
   logic [OP_W-1:0]  r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;

   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_z;
   logic             r_rsp_v;
   logic             r_rsp_n;

   // Accept window, round-robin winner and next state
   always_comb begin
      w_accept    = 1'b0;
      w_grant     = 1'b0;
      w_winner    = 1'b0;
      w_state_nxt = r_state;

      // A new request can be taken when idle, or when the held response
      // leaves in this very cycle.
      w_accept = (r_state == S_IDLE) || ((r_state == S_RESP) && bus.rsp_ready);

      // Under contention the requester that did not win last time goes first.
      if (bus.req0_valid && bus.req1_valid) begin
         w_winner = ~r_last_grant;
      end else begin
         w_winner = bus.req1_valid;
      end

      w_grant = w_accept && (bus.req0_valid || bus.req1_valid);

      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               w_state_nxt = w_grant ? S_EXEC : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_op = w_winner ? bus.req1_op : bus.req0_op;
   assign w_a  = w_winner ? bus.req1_a  : bus.req0_a;
   assign w_b  = w_winner ? bus.req1_b  : bus.req0_b;

   assign bus.req0_ready = w_grant & ~w_winner;
   assign bus.req1_ready = w_grant &  w_winner;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand registers and grant history, loaded only on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_grant) begin
         r_op         <= w_op;
         r_a          <= w_a;
         r_b          <= w_b;
         r_id         <= w_winner;
         r_last_grant <= w_winner;
      end
   end

   // Response capture at the end of EXEC, release on consumer handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_z     <= 1'b0;
         r_rsp_v     <= 1'b0;
         r_rsp_n     <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_rsp_valid <= 1'b1;
         r_rsp_id    <= r_id;
         r_rsp_data  <= bus.alu_out;
         r_rsp_z     <= bus.alu_z;
         r_rsp_v     <= bus.alu_v;
         r_rsp_n     <= bus.alu_n;
      end else if ((r_state == S_RESP) && bus.rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign bus.alu_op   = r_op;
   assign bus.alu_a    = r_a;
   assign bus.alu_b    = r_b;

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_z     = r_rsp_z;
   assign bus.rsp_v     = r_rsp_v;
   assign bus.rsp_n     = r_rsp_n;

   assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: supplies a behavioural ALU_16, runs fixed vectors,
// hand-written multi-cycle sequences and random traffic against a
// transaction-level model of grants, latency and responses.
module tb_alu_arbiter;

   localparam int WIDTH = 16;
   localparam int OP_W  = 3;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_AND   = 3'd2;
   localparam logic [2:0] OP_OR    = 3'd3;
   localparam logic [2:0] OP_XOR   = 3'd4;
   localparam logic [2:0] OP_NAND  = 3'd5;
   localparam logic [2:0] OP_NOTA  = 3'd6;
   localparam logic [2:0] OP_PASSB = 3'd7;

   logic clk = 1'b0;
   logic rst_n;

   alu_arbiter_if #(.WIDTH(WIDTH), .OP_W(OP_W)) ifc();

   alu_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   // ALU_16 behaviour: returns {overflow, result}
   function automatic logic [16:0] alu_ref(input logic [2:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
      int          sa;
      int          sb;
      int          s;
      logic [15:0] r;
      logic        v;
      sa = int'($signed(a));
      sb = int'($signed(b));
      s  = 0;
      r  = 16'h0;
      v  = 1'b0;
      case (op)
         OP_ADD:   begin s = sa + sb; r = 16'(s); v = (s > 32767) || (s < -32768); end
         OP_SUB:   begin s = sa - sb; r = 16'(s); v = (s > 32767) || (s < -32768); end
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_XOR:   r = a ^ b;
         OP_NAND:  r = ~(a & b);
         OP_NOTA:  r = ~a;
         OP_PASSB: r = b;
         default:  r = 16'h0;
      endcase
      return {v, r};
   endfunction

   logic [16:0] w_alu;
   assign w_alu       = alu_ref(ifc.alu_op, ifc.alu_a, ifc.alu_b);
   assign ifc.alu_out = w_alu[15:0];
   assign ifc.alu_v   = w_alu[16];
   assign ifc.alu_z   = (w_alu[15:0] == 16'h0);
   assign ifc.alu_n   = w_alu[15];

   typedef struct {
      logic        id;
      logic [15:0] data;
      logic [2:0]  zvn;
   } rsp_t;

   typedef struct {
      logic        req;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] data;
      logic [2:0]  zvn;
   } vec_t;

   int   n_vec;
   int   n_err;
   bit   mon_en;
   bit   m_pend;
   int   m_age;
   bit   m_last;
   rsp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 1'b0;
      m_age  = 0;
      m_last = 1'b1;
      exp_q.delete();
   endtask

   // Transaction model: at most one operation in flight; its response shows
   // two cycles after acceptance and stays until taken; grants alternate
   // under contention.
   task automatic model();
      logic        exp_rv;
      logic        hs;
      logic        can;
      logic        g;
      logic        w;
      logic [16:0] r;
      rsp_t        e;
      exp_rv = m_pend && (m_age >= 1);
      chk("rsp_valid", 32'(ifc.rsp_valid), 32'(exp_rv));
      if (exp_rv && (exp_q.size() > 0)) begin
         chk("rsp_id",   32'(ifc.rsp_id),   32'(exp_q[0].id));
         chk("rsp_data", 32'(ifc.rsp_data), 32'(exp_q[0].data));
         chk("rsp_zvn",  32'({ifc.rsp_z, ifc.rsp_v, ifc.rsp_n}), 32'(exp_q[0].zvn));
      end
      hs  = exp_rv && ifc.rsp_ready;
      can = !m_pend || hs;
      g   = can && (ifc.req0_valid || ifc.req1_valid);
      w   = (ifc.req0_valid && ifc.req1_valid) ? !m_last : ifc.req1_valid;
      chk("req_ready", 32'({ifc.req1_ready, ifc.req0_ready}), 32'({g && w, g && !w}));
      if (hs) begin
         void'(exp_q.pop_front());
         m_pend = 1'b0;
      end else if (m_pend) begin
         m_age++;
      end
      if (g) begin
         if (w) r = alu_ref(ifc.req1_op, ifc.req1_a, ifc.req1_b);
         else   r = alu_ref(ifc.req0_op, ifc.req0_a, ifc.req0_b);
         e.id   = w;
         e.data = r[15:0];
         e.zvn  = {(r[15:0] == 16'h0), r[16], r[15]};
         exp_q.push_back(e);
         m_pend = 1'b1;
         m_age  = 0;
         m_last = w;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      if (mon_en) model();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
         sample();
         if (ifc.rsp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         advance();
      end
   endtask

   task automatic idle_inputs();
      ifc.req0_valid = 1'b0; ifc.req0_op = '0; ifc.req0_a = '0; ifc.req0_b = '0;
      ifc.req1_valid = 1'b0; ifc.req1_op = '0; ifc.req1_a = '0; ifc.req1_b = '0;
      ifc.rsp_ready  = 1'b1;
   endtask

   vec_t vt[10];
   bit   gr[$];
   bit   ids[$];
   rsp_t held;
   bit   ok;

   initial begin
      n_vec  = 0;
      n_err  = 0;
      mon_en = 1'b0;
      rst_n  = 1'b1;
      idle_inputs();
      model_reset();

      vt[0] = '{1'b0, OP_NAND, 16'h0003, 16'h0005, 16'hFFFE, 3'b001};
      vt[1] = '{1'b1, OP_NAND, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b100};
      vt[2] = '{1'b0, OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 3'b011};
      vt[3] = '{1'b1, OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 3'b100};
      vt[4] = '{1'b0, OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 3'b010};
      vt[5] = '{1'b1, OP_SUB,  16'h1234, 16'h1234, 16'h0000, 3'b100};
      vt[6] = '{1'b0, OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000};
      vt[7] = '{1'b1, OP_OR,   16'hF000, 16'h000F, 16'hF00F, 3'b001};
      vt[8] = '{1'b0, OP_XOR,  16'hAAAA, 16'h5555, 16'hFFFF, 3'b001};
      vt[9] = '{1'b1, OP_ADD,  16'h1234, 16'h1111, 16'h2345, 3'b000};

      // reset state
      #3 rst_n = 1'b0;
      #1;
      chk("rst_busy",      32'(ifc.busy),      32'd0);
      chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      chk("rst_rsp_data",  32'({ifc.rsp_id, ifc.rsp_data, ifc.rsp_z, ifc.rsp_v, ifc.rsp_n}), 32'd0);
      chk("rst_alu_regs",  32'({ifc.alu_op, ifc.alu_a}), 32'd0);
      chk("rst_alu_b",     32'(ifc.alu_b),     32'd0);
      chk("rst_ready",     32'({ifc.req1_ready, ifc.req0_ready}), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;

      // contention: both valid throughout, grants must alternate from 0
      ifc.req0_valid = 1'b1; ifc.req0_op = OP_ADD; ifc.req0_a = 16'h0101; ifc.req0_b = 16'h0202;
      ifc.req1_valid = 1'b1; ifc.req1_op = OP_XOR; ifc.req1_a = 16'h00FF; ifc.req1_b = 16'h0F0F;
      ifc.rsp_ready  = 1'b1;
      for (int c = 0; c < 12; c++) begin
         sample();
         if (ifc.req0_ready) gr.push_back(1'b0);
         if (ifc.req1_ready) gr.push_back(1'b1);
         if (ifc.rsp_valid && ifc.rsp_ready) ids.push_back(ifc.rsp_id);
         advance();
      end
      idle_inputs();
      repeat (3) tick();
      chk("cont_grant_cnt", 32'(gr.size() >= 4), 32'd1);
      chk("cont_rsp_cnt",   32'(ids.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (i < gr.size())  chk("cont_grant", 32'(gr[i]),  32'(i % 2));
         if (i < ids.size()) chk("cont_rsp_id", 32'(ids[i]), 32'(i % 2));
      end

      // fixed vectors, one request at a time
      for (int i = 0; i < 10; i++) begin
         idle_inputs();
         if (vt[i].req) begin
            ifc.req1_valid = 1'b1; ifc.req1_op = vt[i].op; ifc.req1_a = vt[i].a; ifc.req1_b = vt[i].b;
         end else begin
            ifc.req0_valid = 1'b1; ifc.req0_op = vt[i].op; ifc.req0_a = vt[i].a; ifc.req0_b = vt[i].b;
         end
         sample();
         chk("tbl_ready", 32'(vt[i].req ? ifc.req1_ready : ifc.req0_ready), 32'd1);
         advance();
         ifc.req0_valid = 1'b0;
         ifc.req1_valid = 1'b0;
         wait_rsp(ok);
         chk("tbl_rsp_wait", 32'(ok), 32'd1);
         chk("tbl_id",   32'(ifc.rsp_id),   32'(vt[i].req));
         chk("tbl_data", 32'(ifc.rsp_data), 32'(vt[i].data));
         chk("tbl_zvn",  32'({ifc.rsp_z, ifc.rsp_v, ifc.rsp_n}), 32'(vt[i].zvn));
         advance();
      end
      idle_inputs();
      tick();

      // backpressure: response held, no grants, then back-to-back accept
      ifc.rsp_ready  = 1'b0;
      ifc.req0_valid = 1'b1; ifc.req0_op = OP_NAND; ifc.req0_a = 16'h00FF; ifc.req0_b = 16'h0F0F;
      tick();
      ifc.req0_valid = 1'b0;
      ifc.req1_valid = 1'b1; ifc.req1_op = OP_OR; ifc.req1_a = 16'h1000; ifc.req1_b = 16'h0001;
      wait_rsp(ok);
      chk("bp_rsp_wait", 32'(ok), 32'd1);
      chk("bp_data", 32'(ifc.rsp_data), 32'h0000FFF0);
      held.id   = ifc.rsp_id;
      held.data = ifc.rsp_data;
      held.zvn  = {ifc.rsp_z, ifc.rsp_v, ifc.rsp_n};
      advance();
      for (int c = 0; c < 5; c++) begin
         sample();
         chk("bp_stable", 32'({ifc.rsp_valid, ifc.rsp_id, ifc.rsp_data, ifc.rsp_z, ifc.rsp_v, ifc.rsp_n}),
             32'({1'b1, held.id, held.data, held.zvn}));
         chk("bp_no_ready", 32'({ifc.req1_ready, ifc.req0_ready}), 32'd0);
         advance();
      end
      ifc.rsp_ready = 1'b1;
      sample();
      chk("bp_req1_ready", 32'(ifc.req1_ready), 32'd1);
      advance();
      ifc.req1_valid = 1'b0;
      sample();
      chk("bp_gap", 32'(ifc.rsp_valid), 32'd0);
      advance();
      sample();
      chk("bp_next_valid", 32'(ifc.rsp_valid), 32'd1);
      chk("bp_next_data",  32'({ifc.rsp_id, ifc.rsp_data}), 32'h00011001);
      advance();
      tick();

      // reset in EXEC after a requester-0 grant
      ifc.req0_valid = 1'b1; ifc.req0_op = OP_ADD; ifc.req0_a = 16'h1111; ifc.req0_b = 16'h2222;
      tick();
      ifc.req0_valid = 1'b0;
      #2 rst_n = 1'b0;
      mon_en = 1'b0;
      #1;
      chk("mid_rst_busy",  32'(ifc.busy),      32'd0);
      chk("mid_rst_valid", 32'(ifc.rsp_valid), 32'd0);
      chk("mid_rst_alu",   32'({ifc.alu_op, ifc.alu_a}), 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
      for (int c = 0; c < 4; c++) begin
         sample();
         chk("post_rst_no_rsp", 32'(ifc.rsp_valid), 32'd0);
         advance();
      end
      ifc.req0_valid = 1'b1; ifc.req0_op = OP_NOTA;  ifc.req0_a = 16'h00FF;
      ifc.req1_valid = 1'b1; ifc.req1_op = OP_PASSB; ifc.req1_b = 16'h4242;
      sample();
      chk("post_rst_grant", 32'({ifc.req1_ready, ifc.req0_ready}), 32'd1);
      advance();
      idle_inputs();
      repeat (4) tick();

      // operand isolation: inputs change right after accept
      ifc.req0_valid = 1'b1; ifc.req0_op = OP_SUB; ifc.req0_a = 16'h5000; ifc.req0_b = 16'h0100;
      tick();
      ifc.req0_valid = 1'b0; ifc.req0_op = OP_ADD; ifc.req0_a = 16'hDEAD; ifc.req0_b = 16'hBEEF;
      wait_rsp(ok);
      chk("iso_rsp_wait", 32'(ok), 32'd1);
      chk("iso_data", 32'(ifc.rsp_data), 32'h00004F00);
      chk("iso_zvn",  32'({ifc.rsp_z, ifc.rsp_v, ifc.rsp_n}), 32'd0);
      advance();
      idle_inputs();
      tick();

      // random traffic
      for (int c = 0; c < 400; c++) begin
         ifc.req0_valid = ($urandom_range(0, 9) < 6);
         ifc.req0_op    = 3'($urandom_range(0, 7));
         ifc.req0_a     = 16'($urandom());
         ifc.req0_b     = 16'($urandom());
         ifc.req1_valid = ($urandom_range(0, 9) < 6);
         ifc.req1_op    = 3'($urandom_range(0, 7));
         ifc.req1_a     = 16'($urandom());
         ifc.req1_b     = 16'($urandom());
         ifc.rsp_ready  = ($urandom_range(0, 9) < 7);
         tick();
      end
      idle_inputs();
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
